// File: rtl/padctrl_boot_host_if.sv
// padctrl_boot_host_if: packed TL-UL host/device port between the boot host and padctrl.
// tl_o is the h2d request bundle, tl_i the d2h response bundle, seen from the host.
interface padctrl_boot_host_if;
    logic [101:0] tl_o;
    logic [67:0]  tl_i;

    modport master (output tl_o, input tl_i);
    modport slave  (input tl_o, output tl_i);
endinterface

// File: rtl/padctrl_boot_host.sv
// padctrl_boot_host: boot-time TL-UL host writing padctrl attribute registers, then locking.
// Define PADCTRL_BOOT_HOST_VERIFY_EN to add the readback/compare phase.
module padctrl_boot_host #(
    parameter logic [31:0] BaseAddr      = 32'h0,
    parameter logic [7:0]  SourceId      = 8'h0,
    parameter bit          LockAfter     = 1'b1,
    parameter int unsigned TimeoutCycles = 1024
) (
    input  logic                       clk_i,
    input  logic                       rst_ni,
    input  logic                       start_i,
    input  logic [127:0]               mio_attr_cfg_i,
    input  logic [31:0]                dio_attr_cfg_i,
    padctrl_boot_host_if.master        tl,
    output logic                       busy_o,
    output logic                       done_o,
    output logic                       err_o,
    output logic [2:0]                 err_code_o
);

    typedef enum logic [3:0] {
        IDLE     = 4'd0,
        WR_REQ   = 4'd1,
        WR_RSP   = 4'd2,
`ifdef PADCTRL_BOOT_HOST_VERIFY_EN
        RD_REQ   = 4'd3,
        RD_RSP   = 4'd4,
`endif
        LOCK_REQ = 4'd5,
        LOCK_RSP = 4'd6,
        FAIL     = 4'd7,
        FINISH   = 4'd8
    } state_e;

    localparam state_e      Tail = LockAfter ? LOCK_REQ : FINISH;
    localparam logic [31:0] TLim = TimeoutCycles - 1;

    state_e       state_q, state_d;
    logic [2:0]   idx_q, idx_d;
    logic         a_valid_q, a_valid_d;
    logic [31:0]  cnt_q, cnt_d;
    logic         done_q, done_d, err_q, err_d;
    logic [2:0]   code_q, code_d;
    logic [127:0] mio_snap_q;
    logic [31:0]  dio_snap_q;

    logic         d_valid, d_error, a_ready;
    logic [2:0]   d_opcode, exp_dop, fcode;
    logic [7:0]   d_source;
    logic         rd_req, rd_rsp, is_req, is_rsp;
    logic         hs, timeout, fail, start_acc;
    logic [31:0]  word, a_addr, a_data;
    logic         unused_d2h;

    assign d_valid  = tl.tl_i[67];
    assign d_opcode = tl.tl_i[66:64];
    assign d_source = tl.tl_i[58:51];
    assign d_error  = tl.tl_i[1];
    assign a_ready  = tl.tl_i[0];

`ifdef PADCTRL_BOOT_HOST_VERIFY_EN
    logic [31:0] d_data;
    assign d_data     = tl.tl_i[49:18];
    assign unused_d2h = ^{tl.tl_i[63:59], tl.tl_i[50], tl.tl_i[17:2]};
    assign rd_req     = state_q == RD_REQ;
    assign rd_rsp     = state_q == RD_RSP;
`else
    assign unused_d2h = ^{tl.tl_i[63:59], tl.tl_i[50:2]};
    assign rd_req     = 1'b0;
    assign rd_rsp     = 1'b0;
`endif

    assign is_req    = (state_q == WR_REQ) | (state_q == LOCK_REQ) | rd_req;
    assign is_rsp    = (state_q == WR_RSP) | (state_q == LOCK_RSP) | rd_rsp;
    assign busy_o    = is_req | is_rsp;
    assign start_acc = start_i & ~busy_o;
    assign hs        = a_valid_q & a_ready;
    assign exp_dop   = rd_rsp ? 3'd1 : 3'd0;

    // The transaction clock runs from a_valid rise until the response lands.
    assign timeout = (TimeoutCycles != 0) && (cnt_q >= TLim) &&
                     ((a_valid_q & ~a_ready) | (is_rsp & ~d_valid));

    always_comb begin
        case (idx_q)
            3'd1:    word = mio_snap_q[31:0];
            3'd2:    word = mio_snap_q[63:32];
            3'd3:    word = mio_snap_q[95:64];
            3'd4:    word = mio_snap_q[127:96];
            default: word = dio_snap_q;
        endcase
    end

    assign a_addr = (state_q == LOCK_REQ) ? BaseAddr
                  : BaseAddr + {27'd0, idx_q + 3'd1, 2'b00};
    assign a_data = (rd_req | (state_q == LOCK_REQ)) ? 32'd0 : word;

    assign tl.tl_o = a_valid_q
        ? {1'b1, (rd_req ? 3'd4 : 3'd0), 3'd0, 2'd2, SourceId,
           a_addr, 4'hF, a_data, 16'h0, 1'b0}
        : {101'd0, is_rsp};

    always_comb begin
        state_d   = state_q;
        idx_d     = idx_q;
        a_valid_d = a_valid_q;
        cnt_d     = cnt_q + 32'd1;
        done_d    = done_q;
        err_d     = err_q;
        code_d    = code_q;
        fail      = 1'b0;
        fcode     = 3'd0;

        if (is_req) begin
            if (!a_valid_q) begin
                cnt_d     = '0;
                a_valid_d = 1'b1;
            end else if (a_ready) begin
                a_valid_d = 1'b0;
            end
        end

        unique case (state_q)
            IDLE, FINISH, FAIL: begin
                cnt_d   = '0;
                state_d = IDLE;
                if (start_i) begin
                    state_d = WR_REQ;
                    idx_d   = '0;
                    done_d  = 1'b0;
                    err_d   = 1'b0;
                    code_d  = '0;
                end
            end
            WR_REQ:   if (hs) state_d = WR_RSP;
            WR_RSP: begin
                if (d_valid) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = WR_REQ;
                    if (idx_q == 3'd4) begin
                        idx_d = '0;
`ifdef PADCTRL_BOOT_HOST_VERIFY_EN
                        state_d = RD_REQ;
`else
                        state_d = Tail;
`endif
                    end
                end
            end
`ifdef PADCTRL_BOOT_HOST_VERIFY_EN
            RD_REQ:   if (hs) state_d = RD_RSP;
            RD_RSP: begin
                if (d_valid) begin
                    idx_d   = idx_q + 3'd1;
                    state_d = RD_REQ;
                    if (idx_q == 3'd4) begin
                        idx_d   = '0;
                        state_d = Tail;
                    end
                end
            end
`endif
            LOCK_REQ: if (hs) state_d = LOCK_RSP;
            LOCK_RSP: if (d_valid) state_d = FINISH;
            default:  state_d = IDLE;
        endcase

        // Checks in priority order; any failure ends the sequence.
        if (is_req & d_valid) begin
            fail  = 1'b1;
            fcode = 3'd5;
        end else if (is_rsp & d_valid) begin
            if (d_error) begin
                fail  = 1'b1;
                fcode = 3'd1;
            end else if (d_source != SourceId || d_opcode != exp_dop) begin
                fail  = 1'b1;
                fcode = 3'd2;
            end
`ifdef PADCTRL_BOOT_HOST_VERIFY_EN
            else if (rd_rsp && d_data != word) begin
                fail  = 1'b1;
                fcode = 3'd3;
            end
`endif
        end else if (timeout) begin
            fail  = 1'b1;
            fcode = 3'd4;
        end

        if (fail) begin
            state_d   = FAIL;
            a_valid_d = 1'b0;
            done_d    = 1'b1;
            err_d     = 1'b1;
            code_d    = fcode;
        end else if (state_d == FINISH) begin
            done_d = 1'b1;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= IDLE;
            idx_q      <= '0;
            a_valid_q  <= 1'b0;
            cnt_q      <= '0;
            done_q     <= 1'b0;
            err_q      <= 1'b0;
            code_q     <= '0;
            mio_snap_q <= '0;
            dio_snap_q <= '0;
        end else begin
            state_q   <= state_d;
            idx_q     <= idx_d;
            a_valid_q <= a_valid_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
            err_q     <= err_d;
            code_q    <= code_d;
            if (start_acc) begin
                mio_snap_q <= mio_attr_cfg_i;
                dio_snap_q <= dio_attr_cfg_i;
            end
        end
    end

    assign done_o     = done_q;
    assign err_o      = err_q;
    assign err_code_o = code_q;

endmodule

// File: tb/tb_padctrl_boot_host.sv
// tb_padctrl_boot_host: scenario table against a TL-UL register-file responder
// and a transaction-list reference model of the boot programming sequence.
module tb_padctrl_boot_host;

    localparam logic [31:0] BASE  = 32'h4000_0000;
    localparam logic [7:0]  SRC   = 8'h5A;
    localparam int          TO    = 16;
    localparam int          STALL = 7;
`ifdef PADCTRL_BOOT_HOST_VERIFY_EN
    localparam int NT = 11;
    localparam bit VER = 1'b1;
`else
    localparam int NT = 6;
    localparam bit VER = 1'b0;
`endif

    logic         clk = 1'b0;
    logic         rst_ni = 1'b0;
    logic         start = 1'b0;
    logic [127:0] mio = '0;
    logic [31:0]  dio = '0;
    logic         busy, done, err;
    logic [2:0]   code;

    padctrl_boot_host_if tl();

    padctrl_boot_host #(
        .BaseAddr(BASE), .SourceId(SRC), .LockAfter(1'b1), .TimeoutCycles(TO)
    ) dut (
        .clk_i(clk), .rst_ni(rst_ni), .start_i(start),
        .mio_attr_cfg_i(mio), .dio_attr_cfg_i(dio), .tl(tl),
        .busy_o(busy), .done_o(done), .err_o(err), .err_code_o(code)
    );

    always #5 clk = ~clk;

    int npass = 0;
    int ntot  = 0;

    task automatic check(input string nm, input logic [127:0] act,
                         input logic [127:0] exp);
        ntot++;
        if (act === exp) npass++;
        else $display("FAIL %s: actual %0h required %0h", nm, act, exp);
    endtask

    // Responder: a 6-word register file with per-transaction fault injection.
    int            txn_cnt = 0, err_txn = -1, src_txn = -1, zrd_txn = -1;
    int            stall_txn = -1, stall_left = 0, stall_bad = 0, av_cycles = 0;
    bit            no_resp = 1'b0, rsp_pend = 1'b0;
    logic [67:0]   rsp_word = '0;
    logic [101:0]  stall_ref = '0;
    logic [31:0]   mem [6];
    logic [101:0]  obs [$];

    initial begin
        logic [101:0] h;
        logic [67:0]  d;
        logic [31:0]  addr, rdata;
        logic [2:0]   dop;
        int           ri;
        foreach (mem[i]) mem[i] = '0;
        tl.tl_i = '0;
        forever begin
            @(negedge clk);
            h = tl.tl_o;
            d = '0;
            if (rsp_pend) begin
                d = rsp_word;
                rsp_pend = 1'b0;
            end
            if (h[101]) av_cycles++;
            if (h[101] && !no_resp) begin
                if (txn_cnt == stall_txn && stall_left > 0) begin
                    if (stall_left == STALL) stall_ref = h;
                    else if (h !== stall_ref) stall_bad++;
                    stall_left--;
                end else begin
                    if (txn_cnt == stall_txn && h !== stall_ref) stall_bad++;
                    d[0] = 1'b1;
                    obs.push_back(h);
                    addr = h[84:53];
                    ri = int'((addr - BASE) >> 2);
                    if (h[100:98] == 3'd0) begin
                        if (ri >= 0 && ri < 6) mem[ri] = h[48:17];
                        dop = 3'd0;
                        rdata = '0;
                    end else begin
                        dop = 3'd1;
                        rdata = (ri >= 0 && ri < 6) ? mem[ri] : 32'hDEAD_BEEF;
                        if (txn_cnt == zrd_txn) rdata = '0;
                    end
                    rsp_word = {1'b1, dop, 3'd0, 2'd2,
                                (txn_cnt == src_txn) ? ~SRC : SRC, 1'b0,
                                rdata, 16'h0, (txn_cnt == err_txn), 1'b0};
                    rsp_pend = 1'b1;
                    txn_cnt++;
                end
            end
            tl.tl_i = d;
        end
    end

    typedef struct {
        string name;
        int    err_txn;
        int    src_txn;
        int    zrd_txn;
        int    stall_txn;
        bit    no_resp;
        bit    restart;
        int    exp_code;
    } scen_t;

    scen_t tbl [$];

    function automatic logic [101:0] req_word(input logic [2:0] op,
                                              input logic [31:0] a,
                                              input logic [31:0] dt);
        return {1'b1, op, 3'd0, 2'd2, SRC, a, 4'hF, dt, 16'h0, 1'b0};
    endfunction

    task automatic arm(input scen_t s);
        txn_cnt    = 0;
        err_txn    = s.err_txn;
        src_txn    = s.src_txn;
        zrd_txn    = s.zrd_txn;
        stall_txn  = s.stall_txn;
        stall_left = STALL;
        stall_bad  = 0;
        no_resp    = s.no_resp;
        rsp_pend   = 1'b0;
        av_cycles  = 0;
        obs.delete();
    endtask

    task automatic run_scen(input scen_t s);
        logic [101:0] exp_q [$];
        logic [127:0] snap_m;
        logic [31:0]  snap_d, w;
        int           n, mcode, exp_cyc, cyc, av0, ob0;

        @(posedge clk);
        #1;
        arm(s);
        snap_m = {$urandom, $urandom, $urandom, $urandom} | {4{32'h0000_0100}};
        snap_d = $urandom | 32'h1;
        mio = snap_m;
        dio = snap_d;

        // Reference: the full ordered request list, truncated at the first fault.
        for (int i = 0; i < 5; i++) begin
            w = (i == 0) ? snap_d : snap_m[32*(i-1) +: 32];
            exp_q.push_back(req_word(3'd0, BASE + 32'(4*(i+1)), w));
        end
        if (VER)
            for (int i = 0; i < 5; i++)
                exp_q.push_back(req_word(3'd4, BASE + 32'(4*(i+1)), 32'd0));
        exp_q.push_back(req_word(3'd0, BASE, 32'd0));
        n = exp_q.size();
        mcode = 0;
        if (s.no_resp) begin
            n = 0;
            mcode = 4;
        end else begin
            for (int t = 0; t < exp_q.size(); t++) begin
                if (t == s.err_txn) mcode = 1;
                else if (t == s.src_txn) mcode = 2;
                else if (exp_q[t][100:98] == 3'd4 && t == s.zrd_txn) mcode = 3;
                if (mcode != 0) begin
                    n = t + 1;
                    break;
                end
            end
        end
        exp_cyc = s.no_resp ? 1 + TO
                : 3*n + ((s.stall_txn >= 0 && s.stall_txn < n) ? STALL : 0);

        @(negedge clk);
        start = 1'b1;
        @(posedge clk);
        #1;
        check({s.name, "_busy"}, busy, 1'b1);
        cyc = 0;
        while (!done && cyc < 300) begin
            @(negedge clk);
            start = s.restart && cyc == 5;
            if (cyc == 4) begin
                mio = {$urandom, $urandom, $urandom, $urandom};
                dio = $urandom;
            end
            @(posedge clk);
            #1;
            cyc++;
        end
        start = 1'b0;

        check({s.name, "_cycles"}, cyc, exp_cyc);
        check({s.name, "_done"}, done, 1'b1);
        check({s.name, "_busy_end"}, busy, 1'b0);
        check({s.name, "_err"}, err, s.exp_code != 0);
        check({s.name, "_code"}, code, s.exp_code);
        check({s.name, "_model_code"}, code, mcode);
        check({s.name, "_ntxn"}, obs.size(), n);
        for (int i = 0; i < n && i < obs.size(); i++)
            check($sformatf("%s_txn%0d", s.name, i), obs[i], exp_q[i]);
        if (s.stall_txn >= 0) check({s.name, "_stall_stable"}, stall_bad, 0);
        if (s.no_resp) check({s.name, "_avalid_cycles"}, av_cycles, TO);

        av0 = av_cycles;
        ob0 = obs.size();
        repeat (6) @(posedge clk);
        #1;
        check({s.name, "_quiet"}, {av_cycles, obs.size()}, {av0, ob0});
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: actual timeout required finish");
        $fatal(1, "watchdog");
    end

    initial begin
        scen_t s;
        int    cyc;

        tbl.push_back('{"nominal",    -1, -1, -1, -1, 1'b0, 1'b0, 0});
        tbl.push_back('{"stall_mio2", -1, -1, -1,  3, 1'b0, 1'b0, 0});
        tbl.push_back('{"derr_dio",    0, -1, -1, -1, 1'b0, 1'b0, 1});
        tbl.push_back('{"zero_rd",    -1, -1,  7, -1, 1'b0, 1'b0, VER ? 3 : 0});
        tbl.push_back('{"bad_src",    -1,  2, -1, -1, 1'b0, 1'b0, 2});
        tbl.push_back('{"timeout",    -1, -1, -1, -1, 1'b1, 1'b1, 4});
        tbl.push_back('{"derr_lock", NT-1, -1, -1, -1, 1'b0, 1'b0, 1});

        repeat (3) @(posedge clk);
        #1;
        check("rst_tl_o", tl.tl_o, 102'd0);
        check("rst_busy", busy, 1'b0);
        check("rst_done", done, 1'b0);
        check("rst_err", err, 1'b0);
        check("rst_code", code, 3'd0);
        @(negedge clk);
        rst_ni = 1'b1;

        foreach (tbl[i]) run_scen(tbl[i]);

        // Asynchronous reset while the MIO_PADS1 write response is pending.
        s = tbl[0];
        @(posedge clk);
        #1;
        arm(s);
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        cyc = 0;
        while (txn_cnt < 3 && cyc < 100) begin
            @(posedge clk);
            #1;
            cyc++;
        end
        check("rst_mid_reach", txn_cnt, 3);
        #2;
        rst_ni = 1'b0;
        #1;
        check("rst_mid_tl_o", tl.tl_o, 102'd0);
        check("rst_mid_busy", busy, 1'b0);
        check("rst_mid_flags", {done, err, code}, 5'd0);
        @(negedge clk);
        @(negedge clk);
        rst_ni = 1'b1;
        run_scen(s);

        $display("%0d/%0d checks passed", npass, ntot);
        $finish;
    end

endmodule
